// File: rtl/uart_tx_buffered_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_pkg
//   Shared definitions for the buffered UART transmitter: FSM state encoding,
//   frame geometry constants and the bit-period clamp helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_buffered_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // 8N1: one start bit, eight data bits, one stop bit.
   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   // Bit periods shorter than div_min cannot be honoured by the counter
   // scheme (div-1 down to 0), so they are raised to div_min.
   function automatic logic [15:0] clamp_div(input logic [15:0] div,
                                             input logic [15:0] div_min);
      return (div < div_min) ? div_min : div;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_if
//   Byte push port of the buffered UART transmitter (valid/ready handshake).
//   A byte transfers on a rising edge where in_valid && in_ready.
//   Signals:
//     in_valid  producer -> transmitter   byte offered on in_data
//     in_data   producer -> transmitter   byte to transmit
//     in_ready  transmitter -> producer   FIFO can accept
//   Modports: master (byte producer), slave (transmitter).
// -----------------------------------------------------------------------------
interface uart_tx_buffered_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO with occupancy counter.
//   Ports:
//     clk      in   clock, rising edge
//     resetn   in   synchronous active-low reset (pointers and level cleared)
//     push     in   write request; ignored when full
//     wr_data  in   WIDTH-bit write data
//     pop      in   read request; ignored when empty
//     rd_data  out  current head entry (valid while !empty)
//     full     out  level == DEPTH
//     empty    out  level == 0
//     level    out  entries stored, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level_reg == LW'(DEPTH));
   assign empty   = (level_reg == '0);
   assign level   = level_reg;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Head is visible combinationally so the consumer can load it in the same
   // cycle it pops, keeping accept-to-start latency at one edge.
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//   Buffered 8N1 UART transmitter. Bytes pushed over the valid/ready port are
//   queued in a FIFO and serialised LSB first on ser_tx, each bit held for
//   div = max(cfg_div, DIV_MIN) clock cycles. Frames are sent back to back
//   while the FIFO holds data.
//   Ports:
//     clk         in   system clock, rising edge
//     resetn      in   synchronous active-low reset; aborts any frame
//     cfg_div     in   bit period in clk cycles, latched at each frame start
//     bus         slave modport: in_valid / in_data / in_ready
//     ser_tx      out  registered serial line, idle high
//     busy        out  FIFO non-empty or frame in flight
//     fifo_level  out  bytes queued, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_MIN    = 2
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [15:0]                   cfg_div,
   uart_tx_buffered_if.slave             bus,
   output logic                          ser_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   state_t      state_reg;
   logic [15:0] cnt_reg;
   logic [15:0] div_reg;
   logic [2:0]  bit_idx_reg;
   logic [7:0]  shift_reg;
   logic        ser_tx_reg;

   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  head;
   logic        bit_end;
   logic        pop;
   logic [15:0] div_now;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (bus.in_valid),
      .wr_data (bus.in_data),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Ready comes straight from the level register, so a pop while full does
   // not open the port in the same cycle.
   assign bus.in_ready = !fifo_full;

   assign div_now = clamp_div(cfg_div, 16'(DIV_MIN));
   assign bit_end = (cnt_reg == 16'd0);

   // A new frame starts from IDLE, or directly at the last cycle of STOP so
   // consecutive frames have no idle gap.
   assign pop = !fifo_empty &&
                ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         div_reg     <= 16'(DIV_MIN);
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         ser_tx_reg  <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ser_tx_reg <= 1'b1;
               if (pop) begin
                  shift_reg  <= head;
                  div_reg    <= div_now;
                  cnt_reg    <= div_now - 16'd1;
                  ser_tx_reg <= 1'b0;
                  state_reg  <= ST_START;
               end
            end

            ST_START: begin
               if (bit_end) begin
                  ser_tx_reg  <= shift_reg[0];
                  bit_idx_reg <= '0;
                  cnt_reg     <= div_reg - 16'd1;
                  state_reg   <= ST_DATA;
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  cnt_reg <= div_reg - 16'd1;
                  if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
                     ser_tx_reg <= 1'b1;
                     state_reg  <= ST_STOP;
                  end else begin
                     // shift_reg[0] is the bit on the line now; [1] is next.
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     shift_reg   <= shift_reg >> 1;
                     ser_tx_reg  <= shift_reg[1];
                  end
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end

            ST_STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift_reg  <= head;
                     div_reg    <= div_now;
                     cnt_reg    <= div_now - 16'd1;
                     ser_tx_reg <= 1'b0;
                     state_reg  <= ST_START;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end

            default: begin
               state_reg  <= ST_IDLE;
               ser_tx_reg <= 1'b1;
            end
         endcase
      end
   end

   assign ser_tx = ser_tx_reg;

   // Both terms are registers, so busy is glitch-free in practice.
   assign busy = (state_reg != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Directed plus random stimulus for uart_tx_buffered. Accepted bytes are
//   pushed to a scoreboard together with the bit period they must be sent at;
//   a line monitor decodes each frame, checking every bit on its first and
//   last cycle, and compares against the scoreboard head.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [15:0] cfg_div = 16'd106;
   logic        ser_tx;
   logic        busy;
   logic [4:0]  fifo_level;

   uart_tx_buffered_if bus ();

   uart_tx_buffered #(
      .FIFO_DEPTH (16),
      .DIV_MIN    (2)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cfg_div    (cfg_div),
      .bus        (bus),
      .ser_tx     (ser_tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b1;

   typedef struct {
      logic [7:0] data;
      int         div;
      bit         no_gap;
   } exp_t;

   exp_t sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one byte; returns the cycle index of the accepting edge (or -1).
   task automatic push(input logic [7:0] d, input int dv, input bit ng,
                       input int bound, output int acc);
      logic r;
      acc = -1;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int i = 0; i < bound; i++) begin
         r = bus.in_ready;
         @(posedge clk);
         if (r) begin
            if (mon_en) sb.push_back('{d, dv, ng});
            #1;
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      #1;
      bus.in_valid = 1'b0;
      if (acc < 0) check("push_timeout", 0, 1);
   endtask

   task automatic drain(input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && busy === 1'b0) break;
      end
      check("drain_timeout", 32'(i < bound), 1);
   endtask

   // Level and ready invariants, every cycle out of reset.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         assert (fifo_level <= 5'd16) else begin
            fails++;
            $error("FAIL level_bound observed=%0d expected<=16", fifo_level);
         end
         assert (bus.in_ready === (fifo_level != 5'd16)) else begin
            fails++;
            $error("FAIL ready_vs_level observed=%0b expected=%0b", bus.in_ready, fifo_level != 5'd16);
         end
      end
   end

   // Line monitor.
   initial begin
      exp_t       e;
      logic [9:0] o0;
      logic [9:0] o1;
      logic [9:0] ex;
      int         st;
      int         prev_start;
      int         prev_div;
      prev_start = 0;
      prev_div   = 0;
      @(negedge clk);
      forever begin
         if (resetn === 1'b1 && mon_en && ser_tx === 1'b0) begin
            st = cyc;
            if (sb.size() == 0) begin
               check("mon_unexpected_frame", 1, 0);
               e = '{8'h00, 106, 1'b0};
            end else begin
               e = sb.pop_front();
            end
            for (int k = 0; k < 10; k++) begin
               if (k > 0) @(negedge clk);
               o0[k] = ser_tx;
               repeat (e.div - 1) @(negedge clk);
               o1[k] = ser_tx;
            end
            ex = {1'b1, e.data, 1'b0};
            check("frame_first_cycles", 32'(o0), 32'(ex));
            check("frame_last_cycles", 32'(o1), 32'(ex));
            if (e.no_gap) check("no_gap_start", st, prev_start + 10 * prev_div);
            $display("[TB] frame byte=%02h div=%0d start=%0d rx=%02h", e.data, e.div, st, o0[8:1]);
            prev_start = st;
            prev_div   = e.div;
            @(negedge clk);
         end else begin
            @(negedge clk);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int s;
      int acc;
      bit stable;
      bit v;
      logic r;
      logic [7:0] d;

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      resetn       = 1'b0;
      cfg_div      = 16'd106;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ser_tx", ser_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ready", bus.in_ready, 1);
      @(negedge clk);
      resetn = 1'b1;

      // 1: single byte, latency and frame length
      push(8'h41, 106, 1'b0, 10, a);
      check("t1_no_early_start", ser_tx, 1);
      check("t1_level_after_accept", fifo_level, 1);
      @(posedge clk);
      #1;
      s = cyc;
      check("t1_start_latency", ser_tx, 0);
      check("t1_level_after_pop", fifo_level, 0);
      while (cyc < s + 1059) @(negedge clk);
      check("t1_busy_before_end", busy, 1);
      @(negedge clk);
      check("t1_busy_drop", busy, 0);
      check("t1_idle_line", ser_tx, 1);
      drain(200);

      // 2: back-to-back frames
      push(8'h48, 106, 1'b0, 10, acc);
      push(8'h69, 106, 1'b1, 10, acc);
      push(8'h0A, 106, 1'b1, 10, acc);
      drain(4000);

      // 3: fill to full, overflow byte held until first pop
      for (int i = 0; i < 17; i++) begin
         push(8'h80 + 8'(i), 106, i != 0, 10, acc);
         if (i == 0) a = acc;
      end
      @(negedge clk);
      check("t3_level_full", fifo_level, 16);
      check("t3_ready_low", bus.in_ready, 0);
      push(8'h91, 106, 1'b1, 3000, acc);
      check("t3_held_until_pop", acc, a + 1062);
      drain(21000);

      // 4: clamp, then mid-frame divisor change
      cfg_div = 16'd0;
      push(8'h55, 2, 1'b0, 10, acc);
      push(8'h33, 2, 1'b1, 10, acc);
      drain(200);
      cfg_div = 16'd106;
      push(8'h3C, 106, 1'b0, 10, acc);
      repeat (300) @(negedge clk);
      cfg_div = 16'd20;
      push(8'hC3, 20, 1'b1, 10, acc);
      drain(2000);

      // 5: reset during data bit 4
      mon_en  = 1'b0;
      cfg_div = 16'd20;
      push(8'hA5, 20, 1'b0, 10, a);
      push(8'h11, 20, 1'b0, 10, acc);
      s = a + 1;
      while (cyc < s + 110) @(negedge clk);
      check("t5_bit4_value", ser_tx, 0);
      check("t5_busy_mid", busy, 1);
      check("t5_level_mid", fifo_level, 1);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("t5_rst_ser_tx", ser_tx, 1);
      check("t5_rst_level", fifo_level, 0);
      check("t5_rst_busy", busy, 0);
      @(negedge clk);
      resetn = 1'b1;
      stable = 1'b1;
      repeat (300) begin
         @(negedge clk);
         if (ser_tx !== 1'b1) stable = 1'b0;
      end
      check("t5_line_quiet", 32'(stable), 1);
      check("t5_busy_after", busy, 0);
      mon_en = 1'b1;

      // 6: random traffic, dense then sparse
      cfg_div = 16'd3;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         v = (i < 80) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
         d = 8'($urandom);
         bus.in_valid = v;
         bus.in_data  = d;
         r = bus.in_ready;
         @(posedge clk);
         if (v && r) sb.push_back('{d, 3, 1'b0});
         #1;
         bus.in_valid = 1'b0;
      end
      drain(3000);
      check("t6_final_level", fifo_level, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
